// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic             r_id;
    logic             r_resp_id;
    logic [WIDTH-1:0] r_resp_result;
    logic             r_resp_zero;

    logic w_idle;
    logic w_tie_winner;
    logic w_grant;
    logic w_hs;

    assign w_idle = (r_state == S_IDLE);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_tie_winner = 1'b0;
`else
    assign w_tie_winner = ~r_last_grant;
`endif

    // With a single valid requester the grant simply follows req1_valid.
    always_comb begin
        w_grant = req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant = w_tie_winner;
        end
    end

    assign req0_ready = !rst && w_idle && req0_valid && !w_grant;
    assign req1_ready = !rst && w_idle && req1_valid && w_grant;
    assign w_hs       = req0_ready || req1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_id          <= 1'b0;
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_a     <= w_grant ? req1_a  : req0_a;
                        r_b     <= w_grant ? req1_b  : req0_b;
                        r_op    <= w_grant ? req1_op : req0_op;
                        r_id    <= w_grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_last_grant <= w_grant;
`endif
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_resp_result <= alu_result;
                    r_resp_zero   <= alu_zero;
                    r_resp_id     <= r_id;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_op      = r_op;
    assign resp_valid  = (r_state == S_RESP);
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: drives both requesters, models the ALU,
// and predicts grant order, response timing and payload.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]   req0_op, req1_op;
    logic             resp_valid, resp_ready, resp_id, resp_zero;
    logic [WIDTH-1:0] resp_result;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [OPW-1:0]   alu_op;
    logic             alu_zero;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] res;
        logic             zero;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   hs_count = 0;
    int   m_phase  = 0;
    logic m_lg     = 1'b1;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [OPW-1:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd7:    return (a < b) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_ref(alu_a, alu_b, alu_op);
        alu_zero   = (alu_a == alu_b);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: phase model of the FSM, grant prediction and response scoreboard.
    always @(negedge clk) begin
        logic hs0, hs1, exp_w;
        exp_t e;
        if (rst) begin
            q.delete();
            m_phase = 0;
            m_lg    = 1'b1;
        end else begin
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            check_eq("ready_excl", {63'd0, req0_ready && req1_ready}, 64'd0);
            check_eq("resp_valid_timing", {63'd0, resp_valid}, {63'd0, m_phase == 2});
            if (m_phase != 0) begin
                check_eq("ready_while_busy", {63'd0, req0_ready || req1_ready}, 64'd0);
            end else if (req0_valid || req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                exp_w = (req0_valid && req1_valid) ? 1'b0 : req1_valid;
`else
                exp_w = (req0_valid && req1_valid) ? ~m_lg : req1_valid;
`endif
                check_eq("grant_taken", {63'd0, hs0 || hs1}, 64'd1);
                check_eq("grant_id", {63'd0, hs1}, {63'd0, exp_w});
                if (hs0 || hs1) begin
                    e.id   = exp_w;
                    e.res  = exp_w ? alu_ref(req1_a, req1_b, req1_op) : alu_ref(req0_a, req0_b, req0_op);
                    e.zero = exp_w ? (req1_a == req1_b) : (req0_a == req0_b);
                    q.push_back(e);
                    hs_count++;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    m_lg = exp_w;
`endif
                end
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    check_eq("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    check_eq("resp_id", {63'd0, resp_id}, {63'd0, q[0].id});
                    check_eq("resp_result", {32'd0, resp_result}, {32'd0, q[0].res});
                    check_eq("resp_zero", {63'd0, resp_zero}, {63'd0, q[0].zero});
                    if (resp_ready) void'(q.pop_front());
                end
            end
            case (m_phase)
                0: if (hs0 || hs1) m_phase = 1;
                1: m_phase = 2;
                default: if (resp_ready) m_phase = 0;
            endcase
        end
    end

    task automatic wait_hs(input int n);
        int target;
        bit ok;
        target = hs_count + n;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #2;
            if (hs_count >= target) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("hs_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #2;
            if (q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("drain_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [OPW-1:0] op);
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        wait_hs(1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
        check_eq({tag, "_resp_id"}, {63'd0, resp_id}, 64'd0);
        check_eq({tag, "_resp_result"}, {32'd0, resp_result}, 64'd0);
        check_eq({tag, "_resp_zero"}, {63'd0, resp_zero}, 64'd0);
        check_eq({tag, "_alu_a"}, {32'd0, alu_a}, 64'd0);
        check_eq({tag, "_alu_b"}, {32'd0, alu_b}, 64'd0);
        check_eq({tag, "_alu_op"}, {61'd0, alu_op}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        resp_ready = 1'b1;
        // Tie operands are already presented during reset; readies must stay low.
        req0_valid = 1'b1; req0_a = 32'd7;    req0_b = 32'd7;    req0_op = 3'd3;
        req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h3C;   req1_op = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        check_eq("reset_ready0", {63'd0, req0_ready}, 64'd0);
        check_eq("reset_ready1", {63'd0, req1_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Held ties: round-robin alternation (or req0 repeatedly under fixed priority).
        wait_hs(4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Back-pressure with a pending request on the other port.
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd5;          req0_b = 32'd3; req0_op = 3'd2;
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF;  req1_b = 32'd1; req1_op = 3'd2;
        wait_hs(1);
        req0_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_hs(1);
        req1_valid = 1'b0;
        drain();

        issue(1'b1, 32'd2, 32'd9, 3'd7);
        issue(1'b0, 32'd9, 32'd2, 3'd7);
        issue(1'b0, 32'd12, 32'd12, 3'd5);
        issue(1'b1, 32'hF0, 32'h0F, 3'd1);
        issue(1'b0, 32'd3, 32'd5, 3'd3);
        drain();

        // Reset while the accepted operation is in EXEC: it must vanish.
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'd2;
        wait_hs(1);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");

        issue(1'b1, 32'd4, 32'd4, 3'd0);
        req0_valid = 1'b1; req0_a = 32'd6; req0_b = 32'd1; req0_op = 3'd3;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd6; req1_op = 3'd7;
        wait_hs(2);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        check_eq("queue_empty", q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
